dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single-port synchronous data RAM between the CPU load/store port and an
//  external host port (test/IO loader that preloads operands and reads results).
//  Sits between cpu and the data RAM in cpu_top. CPU has priority, with a bounded-wait
//  starvation guard for the host. The block issues one RAM access per cycle and routes
//  read data back to the requester.
// PARAMETERS
//  DATA_W    32  data width of both ports and RAM
//  MEM_AW    10  RAM word-address width; mem_addr = byte_addr[MEM_AW+1:2]
//  MAX_HOLD  4   host wait limit in cycles (1..15); 0 = strict round-robin on contention
// PORTS
//  clk          in   1       system clock, all state on rising edge
//  rst          in   1       asynchronous, active-high reset
//  cpu_addr     in   32      CPU byte address
//  cpu_wdata    in   DATA_W  CPU store data
//  cpu_lw_en    in   1       CPU load request
//  cpu_sw_en    in   1       CPU store request
//  cpu_rdata    out  DATA_W  load data, valid the cycle after a granted CPU load
//  cpu_stall    out  1       CPU request not granted this cycle; CPU holds request
//  host_req     in   1       host access request, held until host_gnt
//  host_we      in   1       1=write, 0=read
//  host_addr    in   32      host byte address
//  host_wdata   in   DATA_W  host write data
//  host_gnt     out  1       host access issued to RAM this cycle
//  host_rvalid  out  1       one-cycle pulse: host_rdata valid (cycle after read grant)
//  host_rdata   out  DATA_W  host read data
//  mem_en       out  1       RAM enable
//  mem_we       out  1       RAM write enable
//  mem_addr     out  MEM_AW  RAM word address
//  mem_wdata    out  DATA_W  RAM write data
//  mem_rdata    in   DATA_W  RAM read data, 1-cycle latency after mem_en
// BEHAVIOUR
//  - cpu_req = cpu_lw_en|cpu_sw_en; both high = store (sw wins), no read-back routed.
//  - Grant (combinational, same cycle): cpu_gnt = cpu_req & ~host_win;
//    host_gnt = host_req & ~cpu_gnt. host_win = host_req & (wait_cnt==MAX_HOLD) when
//    MAX_HOLD>0; when MAX_HOLD==0, host_win = host_req & cpu_req ? last_gnt==CPU : 1.
//  - RAM mux: granted side drives mem_addr/mem_wdata; mem_we = granted write;
//    mem_en = cpu_gnt|host_gnt. No grant -> mem_en=0, mem_we=0, addr/wdata=0.
//  - Low two address bits ignored (word access only); high bits above MEM_AW+1 ignored.
//  - cpu_stall = cpu_req & ~cpu_gnt.
//  - wait_cnt (4b): +1 while host_req & ~host_gnt, saturates at MAX_HOLD;
//    cleared on host_gnt or host_req low.
//  - last_gnt reg: {CPU,HOST}, updated on any grant; reset = HOST (CPU wins first tie).
//  - rd_owner reg: {NONE,CPU,HOST}, set to owner of a granted read, else NONE.
//    rd_owner==HOST -> host_rvalid=1, host_rdata=mem_rdata; else host_rvalid=0,
//    host_rdata held. cpu_rdata = mem_rdata when rd_owner==CPU, else held.
//  - Read latency: grant cycle N -> data at N+1 for either port. Throughput 1 access/cycle.
//  - Reset (async, any time): wait_cnt=0, last_gnt=HOST, rd_owner=NONE, host_rvalid=0,
//    host_rdata=0, cpu_rdata=0; in-flight read returns are dropped. While rst=1 all
//    grants forced 0, mem_en=0, cpu_stall=0.
//  - Host request must stay stable until host_gnt; changing it earlier is undefined.
// TESTING
//  1 CPU sw addr 0x10 data 0xDEADBEEF, no host -> mem_en=1, mem_we=1, mem_addr=4, stall=0.
//  2 host read 0x20, no CPU -> host_gnt same cycle, mem_addr=8; next cycle host_rvalid=1,
//    host_rdata = RAM model word 8; cpu_rdata unchanged.
//  3 MAX_HOLD=4, CPU load + host read held continuously -> host_gnt on 5th cycle only,
//    cpu_stall=1 that cycle; pattern repeats every 5 cycles; data routed to correct port.
//  4 MAX_HOLD=0, both held -> grants alternate CPU,HOST,CPU,... starting with CPU.
//  5 cpu_lw_en=cpu_sw_en=1 addr 0x4 -> store issued, no cpu_rdata update next cycle.
//  6 assert rst in cycle after host read grant -> host_rvalid stays 0, wait_cnt=0,
//    after release first tie goes to CPU.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data RAM between the CPU load/store port and the host loader port.
// CPU has priority; a bounded-wait counter (or round-robin when MAX_HOLD=0) keeps the host from starving.
module dmem_arbiter #(
  parameter int DATA_W   = 32,
  parameter int MEM_AW   = 10,
  parameter int MAX_HOLD = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_lw_en,
  input  logic              cpu_sw_en,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [31:0]       host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic {LAST_CPU, LAST_HOST} last_t;
  typedef enum logic [1:0] {RD_NONE, RD_CPU, RD_HOST} owner_t;

  localparam logic [3:0] WAIT_MAX = 4'(MAX_HOLD);

  last_t             last_gnt;
  owner_t            rd_owner;
  logic [3:0]        wait_cnt;
  logic              cpu_req;
  logic              cpu_gnt;
  logic              host_win;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic [DATA_W-1:0] host_rdata_q;
  logic              unused_addr_bits;

  assign cpu_req = cpu_lw_en | cpu_sw_en;

  // Reset also masks the grants so nothing reaches the RAM while rst is high.
  always_comb begin
    host_win = 1'b0;
    if (MAX_HOLD > 0)
      host_win = host_req && (wait_cnt == WAIT_MAX);
    else
      host_win = host_req && (cpu_req ? (last_gnt == LAST_CPU) : 1'b1);
    cpu_gnt   = !rst && cpu_req && !host_win;
    host_gnt  = !rst && host_req && !cpu_gnt;
    cpu_stall = !rst && cpu_req && !cpu_gnt;
  end

  always_comb begin
    mem_en    = cpu_gnt | host_gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpu_gnt) begin
      mem_we    = cpu_sw_en;
      mem_addr  = cpu_addr[MEM_AW+1:2];
      mem_wdata = cpu_wdata;
    end else if (host_gnt) begin
      mem_we    = host_we;
      mem_addr  = host_addr[MEM_AW+1:2];
      mem_wdata = host_wdata;
    end
  end

  assign unused_addr_bits = ^{cpu_addr[31:MEM_AW+2], cpu_addr[1:0],
                              host_addr[31:MEM_AW+2], host_addr[1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      wait_cnt <= '0;
    else if (host_req && !host_gnt) begin
      if (wait_cnt != WAIT_MAX)
        wait_cnt <= wait_cnt + 4'd1;
    end else
      wait_cnt <= '0;
  end

  // A simultaneous load+store is treated as a store, so no read-back is routed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_gnt <= LAST_HOST;
      rd_owner <= RD_NONE;
    end else begin
      if (cpu_gnt)
        last_gnt <= LAST_CPU;
      else if (host_gnt)
        last_gnt <= LAST_HOST;
      if (cpu_gnt && cpu_lw_en && !cpu_sw_en)
        rd_owner <= RD_CPU;
      else if (host_gnt && !host_we)
        rd_owner <= RD_HOST;
      else
        rd_owner <= RD_NONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpu_rdata_q  <= '0;
      host_rdata_q <= '0;
    end else begin
      if (rd_owner == RD_CPU)
        cpu_rdata_q <= mem_rdata;
      if (rd_owner == RD_HOST)
        host_rdata_q <= mem_rdata;
    end
  end

  assign host_rvalid = (rd_owner == RD_HOST);
  assign host_rdata  = host_rvalid ? mem_rdata : host_rdata_q;
  assign cpu_rdata   = (rd_owner == RD_CPU) ? mem_rdata : cpu_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: a priority instance (MAX_HOLD=4) and a round-robin instance (MAX_HOLD=0)
// share stimulus; a reference model fills a scoreboard that a negedge monitor drains.
module tb_dmem_arbiter;

  localparam int DW = 32;
  localparam int AW = 10;
  localparam int MH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [31:0]   cpu_addr = '0, host_addr = '0;
  logic [DW-1:0] cpu_wdata = '0, host_wdata = '0;
  logic          cpu_lw_en = 1'b0, cpu_sw_en = 1'b0, host_req = 1'b0, host_we = 1'b0;

  logic [DW-1:0] cpu_rdata, host_rdata, mem_wdata, mem_rdata;
  logic          cpu_stall, host_gnt, host_rvalid, mem_en, mem_we;
  logic [AW-1:0] mem_addr;

  logic [DW-1:0] rr_cpu_rdata, rr_host_rdata, rr_mem_wdata, rr_mem_rdata;
  logic          rr_cpu_stall, rr_host_gnt, rr_host_rvalid, rr_mem_en, rr_mem_we;
  logic [AW-1:0] rr_mem_addr;

  assign rr_mem_rdata = '0;

  always #5 clk = ~clk;

  dmem_arbiter #(.DATA_W(DW), .MEM_AW(AW), .MAX_HOLD(MH)) u_pri (
    .clk(clk), .rst(rst),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_lw_en(cpu_lw_en), .cpu_sw_en(cpu_sw_en),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  dmem_arbiter #(.DATA_W(DW), .MEM_AW(AW), .MAX_HOLD(0)) u_rr (
    .clk(clk), .rst(rst),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_lw_en(cpu_lw_en), .cpu_sw_en(cpu_sw_en),
    .cpu_rdata(rr_cpu_rdata), .cpu_stall(rr_cpu_stall),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(rr_host_gnt), .host_rvalid(rr_host_rvalid), .host_rdata(rr_host_rdata),
    .mem_en(rr_mem_en), .mem_we(rr_mem_we), .mem_addr(rr_mem_addr), .mem_wdata(rr_mem_wdata),
    .mem_rdata(rr_mem_rdata)
  );

  function automatic logic [31:0] init_word(input int a);
    return (32'(a) * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction

  // Synchronous RAM behind the priority instance; unwritten words read a fixed pattern.
  logic [DW-1:0] ram [0:(1<<AW)-1];
  bit            ram_ok [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        ram[mem_addr]    <= mem_wdata;
        ram_ok[mem_addr] <= 1'b1;
      end else
        mem_rdata <= ram_ok[mem_addr] ? ram[mem_addr] : init_word(int'(mem_addr));
    end
  end

  typedef struct {
    bit            stall, hgnt, en, we, hvalid, rr_stall, rr_hgnt;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata, cdata, hdata;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] hrd_q[$];
  int            n_pass = 0;
  int            n_checks = 0;

  // Reference model state: how long the host has been refused, who won the last round-robin
  // tie, and which read (if any) returns next cycle.
  logic [DW-1:0] ref_mem [int];
  int            m_hwait = 0;
  bit            m_last_cpu = 1'b0;
  int            pend = 0;
  logic [DW-1:0] pend_data = '0, m_cdata = '0, m_hdata = '0;

  function automatic logic [31:0] rd_word(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp)
      n_pass++;
    else
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic applyStimulus(input bit r, input bit lw, input bit sw,
                               input logic [31:0] ca, input logic [31:0] cw,
                               input bit hr, input bit hwe,
                               input logic [31:0] ha, input logic [31:0] hw,
                               output bit hdone);
    exp_t e;
    bit   creq, cg, hg, rcg, rg;
    int   a;
    @(posedge clk);
    #2;
    rst = r; cpu_lw_en = lw; cpu_sw_en = sw; cpu_addr = ca; cpu_wdata = cw;
    host_req = hr; host_we = hwe; host_addr = ha; host_wdata = hw;
    e = '{default: 0};
    hdone = 1'b0;
    creq = lw | sw;
    if (r) begin
      m_hwait = 0; m_last_cpu = 1'b0; pend = 0; m_cdata = '0; m_hdata = '0;
      hrd_q.delete();
    end else begin
      if (pend == 1) m_cdata = pend_data;
      if (pend == 2) begin m_hdata = pend_data; e.hvalid = 1'b1; end
      pend = 0;
      cg  = creq && !(hr && m_hwait >= MH);
      hg  = hr && !cg;
      rcg = creq && !(hr && m_last_cpu);
      rg  = hr && !rcg;
      if (rcg) m_last_cpu = 1'b1;
      else if (rg) m_last_cpu = 1'b0;
      m_hwait = (hr && !hg) ? ((m_hwait + 1 > MH) ? MH : m_hwait + 1) : 0;
      e.stall = creq && !cg; e.hgnt = hg;
      e.rr_stall = creq && !rcg; e.rr_hgnt = rg;
      if (cg) begin
        a = int'(ca[AW+1:2]);
        e.en = 1'b1; e.we = sw; e.addr = AW'(a); e.wdata = cw;
        if (sw) ref_mem[a] = cw;
        else begin pend = 1; pend_data = rd_word(a); end
      end else if (hg) begin
        a = int'(ha[AW+1:2]);
        e.en = 1'b1; e.we = hwe; e.addr = AW'(a); e.wdata = hw;
        if (hwe) ref_mem[a] = hw;
        else begin pend = 2; pend_data = rd_word(a); hrd_q.push_back(pend_data); end
      end
      hdone = hg && rg;
    end
    e.cdata = m_cdata;
    e.hdata = m_hdata;
    exp_q.push_back(e);
  endtask

  // Monitor: compares every cycle that has an expectation, and pops host read data on rvalid.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput("cpu_stall", 32'(cpu_stall), 32'(e.stall));
        checkOutput("host_gnt", 32'(host_gnt), 32'(e.hgnt));
        checkOutput("mem_en", 32'(mem_en), 32'(e.en));
        checkOutput("mem_we", 32'(mem_we), 32'(e.we));
        checkOutput("mem_addr", 32'(mem_addr), 32'(e.addr));
        checkOutput("mem_wdata", mem_wdata, e.wdata);
        checkOutput("host_rvalid", 32'(host_rvalid), 32'(e.hvalid));
        checkOutput("cpu_rdata", cpu_rdata, e.cdata);
        checkOutput("host_rdata", host_rdata, e.hdata);
        checkOutput("rr_cpu_stall", 32'(rr_cpu_stall), 32'(e.rr_stall));
        checkOutput("rr_host_gnt", 32'(rr_host_gnt), 32'(e.rr_hgnt));
      end
      if (host_rvalid) begin
        if (hrd_q.size() == 0)
          checkOutput("host_rvalid_unexpected", 32'(host_rvalid), 32'd0);
        else
          checkOutput("host_read_data", host_rdata, hrd_q.pop_front());
      end
    end
  end

  function automatic logic [31:0] rand_addr();
    return ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2) |
           32'($urandom_range(0, 3));
  endfunction

  initial begin
    bit            hd, hheld, r, lw, sw, hr, hwe;
    logic [31:0]   ca, cw, ha, hw;
    $display("[TB] start");
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, hd);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, hd);
    // CPU store alone, then host read alone, then an idle cycle for the return.
    applyStimulus(0, 0, 1, 32'h10, 32'hDEAD_BEEF, 0, 0, 0, 0, hd);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 32'h20, 0, hd);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, hd);
    // Both sides held: host every fifth cycle on u_pri, alternation on u_rr.
    for (int i = 0; i < 12; i++)
      applyStimulus(0, 1, 0, 32'h10, 0, 1, 0, 32'h20, 0, hd);
    applyStimulus(0, 1, 1, 32'h4, 32'h1234_5678, 0, 0, 0, 0, hd);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, hd);
    applyStimulus(0, 1, 0, 32'h4, 0, 0, 0, 0, 0, hd);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, hd);
    // Reset right after a host read grant, then a tie after release.
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 32'h10, 0, hd);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, hd);
    applyStimulus(0, 1, 0, 32'h20, 0, 1, 1, 32'h30, 32'hCAFE_F00D, hd);
    applyStimulus(0, 0, 0, 0, 0, 1, 1, 32'h30, 32'hCAFE_F00D, hd);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, hd);
    // Randomized traffic; the host holds its request until both instances granted it.
    hheld = 1'b0; hr = 1'b0; hwe = 1'b0; ha = '0; hw = '0;
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 59) == 0);
      if (!hheld) begin
        hr = ($urandom_range(0, 2) != 0); hwe = 1'($urandom_range(0, 1));
        ha = rand_addr(); hw = $urandom;
      end
      lw = ($urandom_range(0, 2) != 0); sw = ($urandom_range(0, 2) == 0);
      ca = rand_addr(); cw = $urandom;
      applyStimulus(r, lw, sw, ca, cw, hr, hwe, ha, hw, hd);
      hheld = hr && !hd && !r;
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, hd);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, hd);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    checkOutput("host_reads_returned", 32'(hrd_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
